snitch_testharness: RTL and testbench



---
 rtl/snitch_testharness.sv | 109 ++++++++++
 tb/tb_snitch_testharness.sv | 176 +++++++++++++++++
 2 files changed

// File: rtl/snitch_testharness.sv
// Self-checking SRAM harness: writes PATTERN(i) to N words, reads them back, sums and compares; eoc_o at edge 2N+2.
// Optional build macro TESTHARNESS_FAULT_INJECT_EN corrupts bit 0 of word 3 during the write pass.
module snitch_testharness #(
    parameter int          MEM_WORDS      = 256,
    parameter int          NUM_TEST_WORDS = 16,
    parameter logic [31:0] SEED           = 32'h0000_0000,
    parameter int          TIMEOUT_CYCLES = 1000
) (
    input  logic        clk_i,
    input  logic        rst_i,
    output logic        eoc_o,
    output logic [31:0] exit_code_o,
    output logic [31:0] checksum_o,
    output logic [31:0] cycle_cnt_o
);

    localparam int              AW        = (MEM_WORDS > 1) ? $clog2(MEM_WORDS) : 1;
    localparam logic [AW-1:0]   LAST_ADDR = AW'(NUM_TEST_WORDS - 1);
    localparam logic [31:0]     GOLDEN    = 32'h9E37_79B9;
    localparam logic [31:0]     TMO_LAST  = 32'(TIMEOUT_CYCLES - 1);

    typedef enum logic [2:0] {IDLE, WRITE, READ, DRAIN, DONE} state_t;

    state_t        state;
    state_t        state_nxt;
    logic [AW-1:0] addr;
    logic [31:0]   mem [MEM_WORDS];
    logic [31:0]   rdata;
    logic [31:0]   exp_data;
    logic [31:0]   wdata;
    logic [31:0]   mismatch;
    logic [31:0]   mismatch_nxt;
    logic          rd_vld;
    logic          mem_we;
    logic          mem_re;
    logic          timeout;

    function automatic logic [31:0] pattern(input logic [AW-1:0] a);
        return (32'(a) * GOLDEN) ^ SEED;
    endfunction

    always_ff @(posedge clk_i) begin
        if (rst_i) state <= IDLE;
        else       state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        timeout   = 1'b0;
        case (state)
            IDLE:    state_nxt = WRITE;
            WRITE:   if (addr == LAST_ADDR) state_nxt = READ;
            READ:    if (addr == LAST_ADDR) state_nxt = DRAIN;
            DRAIN:   state_nxt = DONE;
            DONE:    state_nxt = DONE;
            default: state_nxt = IDLE;
        endcase
        // Watchdog only fires when this edge is not already a normal completion.
        if (state != DONE && state_nxt != DONE && cycle_cnt_o == TMO_LAST) begin
            state_nxt = DONE;
            timeout   = 1'b1;
        end
    end

    always_comb begin
        mem_we = (state == WRITE);
        mem_re = (state == READ);
        wdata  = pattern(addr);
`ifdef TESTHARNESS_FAULT_INJECT_EN
        if (NUM_TEST_WORDS > 3 && addr == AW'(3)) wdata[0] = ~wdata[0];
`endif
    end

    // SRAM array is deliberately not reset; read data lands one cycle after the address edge.
    always_ff @(posedge clk_i) begin
        if (mem_we) mem[addr] <= wdata;
        if (mem_re) rdata <= mem[addr];
    end

    assign mismatch_nxt = mismatch + {31'b0, rd_vld && (rdata != exp_data)};

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            addr        <= '0;
            rd_vld      <= 1'b0;
            exp_data    <= '0;
            mismatch    <= '0;
            checksum_o  <= '0;
            cycle_cnt_o <= '0;
            eoc_o       <= 1'b0;
            exit_code_o <= '0;
        end else begin
            rd_vld   <= mem_re;
            exp_data <= pattern(addr);
            if (state == WRITE || state == READ)
                addr <= (addr == LAST_ADDR) ? '0 : addr + 1'b1;
            if (state != DONE) begin
                cycle_cnt_o <= cycle_cnt_o + 32'd1;
                mismatch    <= mismatch_nxt;
                checksum_o  <= checksum_o + (rd_vld ? rdata : 32'd0);
            end
            if (state != DONE && state_nxt == DONE) begin
                eoc_o       <= 1'b1;
                exit_code_o <= timeout ? 32'hFFFF_FFFF : mismatch_nxt;
            end
        end
    end

endmodule

// File: tb/tb_snitch_testharness.sv
// Bench for snitch_testharness: several parameterisations share clock and reset; results checked against an arithmetic model.
module tb_snitch_testharness;

    localparam int ND = 5;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        eoc [ND];
    logic [31:0] ex  [ND];
    logic [31:0] cs  [ND];
    logic [31:0] cc  [ND];

    int tests = 0;
    int fails = 0;

    always #5 clk = ~clk;

    snitch_testharness u0 (
        .clk_i(clk), .rst_i(rst), .eoc_o(eoc[0]), .exit_code_o(ex[0]), .checksum_o(cs[0]), .cycle_cnt_o(cc[0]));
    snitch_testharness #(.NUM_TEST_WORDS(2), .SEED(32'h0)) u1 (
        .clk_i(clk), .rst_i(rst), .eoc_o(eoc[1]), .exit_code_o(ex[1]), .checksum_o(cs[1]), .cycle_cnt_o(cc[1]));
    snitch_testharness #(.TIMEOUT_CYCLES(20)) u2 (
        .clk_i(clk), .rst_i(rst), .eoc_o(eoc[2]), .exit_code_o(ex[2]), .checksum_o(cs[2]), .cycle_cnt_o(cc[2]));
    snitch_testharness #(.NUM_TEST_WORDS(256)) u3 (
        .clk_i(clk), .rst_i(rst), .eoc_o(eoc[3]), .exit_code_o(ex[3]), .checksum_o(cs[3]), .cycle_cnt_o(cc[3]));
    snitch_testharness #(.NUM_TEST_WORDS(5), .SEED(32'hC0FF_EE11)) u4 (
        .clk_i(clk), .rst_i(rst), .eoc_o(eoc[4]), .exit_code_o(ex[4]), .checksum_o(cs[4]), .cycle_cnt_o(cc[4]));

    typedef struct {
        int          n;
        int          tmo;
        logic [31:0] seed;
        int          edge_e;
        logic [31:0] exit_e;
        logic [31:0] cs_e;
        bit          chk_cs;
    } vec_t;

    vec_t vt [ND];

    int          seen_edge [ND];
    logic [31:0] r_ex [ND];
    logic [31:0] r_cs [ND];
    logic [31:0] r_cc [ND];

    // Reference model: what the memory should hold, and what the harness should report.
    function automatic logic [31:0] m_clean(input int i, input logic [31:0] seed);
        return (32'(i) * 32'h9E37_79B9) ^ seed;
    endfunction

    function automatic logic [31:0] m_stored(input int i, input logic [31:0] seed);
        logic [31:0] p;
        p = m_clean(i, seed);
`ifdef TESTHARNESS_FAULT_INJECT_EN
        if (i == 3) p[0] = ~p[0];
`endif
        return p;
    endfunction

    function automatic vec_t m_vec(input int n, input int tmo, input logic [31:0] seed);
        vec_t v;
        int   mis;
        v.n = n; v.tmo = tmo; v.seed = seed;
        v.cs_e = 32'd0;
        mis = 0;
        for (int i = 0; i < n; i++) begin
            v.cs_e += m_stored(i, seed);
            if (m_stored(i, seed) != m_clean(i, seed)) mis++;
        end
        if (2 * n + 2 <= tmo) begin
            v.edge_e = 2 * n + 2; v.exit_e = 32'(mis); v.chk_cs = 1'b1;
        end else begin
            v.edge_e = tmo; v.exit_e = 32'hFFFF_FFFF; v.chk_cs = 1'b0;
        end
        return v;
    endfunction

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic run_rec(input int max_e);
        for (int k = 0; k < ND; k++) seen_edge[k] = -1;
        for (int e = 1; e <= max_e; e++) begin
            tick();
            for (int k = 0; k < ND; k++) begin
                if (eoc[k] === 1'b1 && seen_edge[k] < 0) begin
                    seen_edge[k] = e;
                    r_ex[k] = ex[k];
                    r_cs[k] = cs[k];
                    r_cc[k] = cc[k];
                end
            end
        end
    endtask

    task automatic chk_zero(input string tag);
        for (int k = 0; k < ND; k++) begin
            chk($sformatf("%s_eoc%0d", tag, k), 32'(eoc[k]), 32'd0);
            chk($sformatf("%s_exit%0d", tag, k), ex[k], 32'd0);
            chk($sformatf("%s_cs%0d", tag, k), cs[k], 32'd0);
            chk($sformatf("%s_cc%0d", tag, k), cc[k], 32'd0);
        end
    endtask

    initial begin
        int ab;
        int hold;
        vt[0] = m_vec(16, 1000, 32'h0);
        vt[1] = m_vec(2, 1000, 32'h0);
        vt[2] = m_vec(16, 20, 32'h0);
        vt[3] = m_vec(256, 1000, 32'h0);
        vt[4] = m_vec(5, 1000, 32'hC0FF_EE11);

        rst = 1'b1;
        tick();
        tick();
        chk_zero("reset");
        rst = 1'b0;

        // Long enough for the 256-word run plus >100 frozen cycles on the default instance.
        run_rec(620);
        for (int k = 0; k < ND; k++) begin
            chk($sformatf("eoc_edge%0d", k), 32'(seen_edge[k]), 32'(vt[k].edge_e));
            chk($sformatf("exit%0d", k), r_ex[k], vt[k].exit_e);
            chk($sformatf("cc_at_eoc%0d", k), r_cc[k], 32'(vt[k].edge_e));
            if (vt[k].chk_cs) chk($sformatf("checksum%0d", k), r_cs[k], vt[k].cs_e);
            chk($sformatf("frozen_eoc%0d", k), 32'(eoc[k]), 32'd1);
            chk($sformatf("frozen_cc%0d", k), cc[k], r_cc[k]);
            chk($sformatf("frozen_exit%0d", k), ex[k], r_ex[k]);
            chk($sformatf("frozen_cs%0d", k), cs[k], r_cs[k]);
        end
        chk("n2_checksum_literal", r_cs[1], 32'h9E37_79B9);
        chk("timeout_exit_literal", r_ex[2], 32'hFFFF_FFFF);

        // Mid-run aborts: first at edge 10, then at random points and with random hold lengths.
        for (int it = 0; it < 4; it++) begin
            rst = 1'b1;
            tick();
            rst = 1'b0;
            ab = (it == 0) ? 10 : $urandom_range(3, 45);
            for (int e = 1; e < ab; e++) tick();
            chk($sformatf("mid_cc_it%0d", it), cc[0], 32'((ab - 1 < vt[0].edge_e) ? ab - 1 : vt[0].edge_e));
            chk($sformatf("mid_eoc_it%0d", it), 32'(eoc[0]), 32'((ab - 1 >= vt[0].edge_e) ? 1 : 0));
            rst = 1'b1;
            tick();
            chk_zero($sformatf("abort_it%0d", it));
            hold = $urandom_range(0, 2);
            for (int h = 0; h < hold; h++) tick();
            chk($sformatf("hold_cc_it%0d", it), cc[0], 32'd0);
            rst = 1'b0;
            run_rec(45);
            for (int k = 0; k < ND; k++) begin
                if (vt[k].edge_e <= 45) begin
                    chk($sformatf("rerun_edge_it%0d_%0d", it, k), 32'(seen_edge[k]), 32'(vt[k].edge_e));
                    chk($sformatf("rerun_exit_it%0d_%0d", it, k), r_ex[k], vt[k].exit_e);
                    if (vt[k].chk_cs)
                        chk($sformatf("rerun_cs_it%0d_%0d", it, k), r_cs[k], vt[k].cs_e);
                end
            end
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
